imem_resp: RTL
==============

Name: imem_resp

Overview:
- Instruction-memory responder on the far side of the fetch-stage request interface.
- Samples the fetch stage's PC and instruction-request each cycle and returns the addressed instruction one cycle later with a valid flag and fault flag.
- Owns the instruction RAM and a byte-serial load port that fills the RAM before and between runs.
- Holds the fetch stage via o_stall while no program is loaded or a load is in progress.

Parameters:
- DEPTH, 256, number of INSTR_W-bit words in the RAM; power of two, at least 2.
- ADDR_W, `ADDR_W (32), PC width.
- INSTR_W, `INSTR_W (32), instruction width; multiple of 8.
- NOP, 32'h00000013, instruction returned on any fault.

Ports:
- clk  in  1  clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- i_pc  in  ADDR_W  fetch PC from the fetch stage.
- i_instr_req  in  1  fetch request.
- i_stall  in  1  downstream hold; freezes the response registers.
- o_instr  out  INSTR_W  returned instruction.
- o_instr_valid  out  1  o_instr is a live response.
- o_fault  out  1  response was misaligned or out of range.
- o_stall  out  1  asserted while the fetch stage must hold.
- i_ld_start  in  1  pulse; begin a load at word 0.
- i_ld_valid  in  1  i_ld_byte is valid this cycle.
- i_ld_byte  in  8  load data byte, little-endian within a word.
- i_ld_end  in  1  pulse; finish the load.
- o_ld_ovf  out  1  sticky: load data was dropped past DEPTH words.

Behaviour:
- Reset (async, clr_n=0):
  - state=HALT, load pointer=0, byte count=0.
  - o_instr=0, o_instr_valid=0, o_fault=0, o_ld_ovf=0, o_stall=1.
  - RAM contents are not reset.
- FSM states: HALT, LOAD, RUN.
  - HALT -i_ld_start-> LOAD.
  - LOAD -i_ld_end-> RUN.
  - RUN -i_ld_start-> LOAD.
  - i_ld_start in LOAD restarts the load: pointer=0, byte count=0, o_ld_ovf cleared.
  - Entering LOAD from any state always clears the pointer, byte count and o_ld_ovf.
- o_stall = 1 in HALT and LOAD, 0 in RUN. Combinational from state.
- Load path:
  - Each i_ld_valid byte in LOAD (or in the i_ld_start cycle) shifts into the assembly register at lane byte count.
  - When INSTR_W/8 bytes are collected, the word is written to RAM[pointer], pointer increments, byte count returns to 0.
  - If pointer == DEPTH, the word is discarded and o_ld_ovf sets (sticky).
  - i_ld_valid with i_ld_start in the same cycle: the byte is lane 0 of word 0.
  - i_ld_valid with i_ld_end in the same cycle: the byte is included.
  - A partial word at i_ld_end is zero-padded in the upper lanes and written.
  - Bytes arriving in HALT or RUN without i_ld_start are ignored.
- Fetch path (RUN only):
  - With i_stall=0, i_instr_req is sampled each cycle.
  - One-cycle latency: request at edge t gives o_instr/o_instr_valid/o_fault at t+1.
  - Word index = i_pc >> log2(INSTR_W/8).
  - Fault if the low log2(INSTR_W/8) bits are nonzero, or index >= DEPTH (upper PC bits nonzero). A fault returns NOP with o_fault=1 and o_instr_valid=1.
  - i_instr_req=0 gives o_instr_valid=0 next cycle; o_instr holds its last value.
- i_stall=1: o_instr, o_instr_valid and o_fault hold; the request is not sampled.
- Outside RUN: o_instr_valid=0, o_fault=0 next cycle, regardless of i_stall.
- RUN->LOAD mid-stream: the response in flight is dropped (valid=0 next cycle).
- A RAM write and a fetch read never coincide, because fetch is only served in RUN.

Optional Feature:
- Macro IMEM_RESP_PC_EN.
- Defined: adds output o_resp_pc, width ADDR_W, reset 0.
  - Registered with the PC of each sampled request.
  - Held under i_stall, alongside o_instr.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- config.vh:
  - ADDR_W, INSTR_W.
  - NOP encoding.
  - FSM state encodings (IMEM_HALT, IMEM_LOAD, IMEM_RUN).
- Sub-module imem_ld_asm: byte-to-word assembler.
  - Holds the byte count and the assembly register.
  - Produces a word-valid strobe plus the padded word on end.
- imem_resp holds the FSM, pointer, RAM and response registers.

Test Plan:
- Reset, then idle 5 cycles -> o_stall=1, o_instr_valid=0, o_instr=0 throughout.
- i_ld_start, bytes 13 00 00 00 93 00 10 00, i_ld_end -> o_stall falls the next cycle; then:
  - fetch pc=0 -> o_instr=32'h00000013, valid=1.
  - fetch pc=4 -> o_instr=32'h00100093, valid=1.
- Load 5 bytes AA BB CC DD EE, end -> RAM[1]=32'h000000EE; fetch pc=4 returns it with o_fault=0.
- In RUN, fetch pc=2 and pc=4*DEPTH -> each returns NOP, o_fault=1, valid=1; the next good fetch clears o_fault.
- Load 4*DEPTH+4 bytes -> o_ld_ovf=1 and RAM[0] unchanged; a subsequent i_ld_start clears o_ld_ovf.
- In RUN, alternate i_stall 1/0 with pc stepping 0,4,8 -> outputs freeze while stalled, no request is lost or duplicated; assert clr_n low mid-stream -> all outputs are at reset values immediately.

Source files
------------

// File: rtl/imem_resp_pkg.sv
// Shared configuration for the instruction-memory responder: default widths,
// the fault NOP encoding and the FSM state type.
package imem_resp_pkg;

    localparam int unsigned IMEM_ADDR_W  = 32;
    localparam int unsigned IMEM_INSTR_W = 32;
    localparam logic [31:0] IMEM_NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        IMEM_HALT = 2'd0,
        IMEM_LOAD = 2'd1,
        IMEM_RUN  = 2'd2
    } imem_state_e;

    // log2 of the number of byte lanes in an instruction word
    function automatic int unsigned lane_bits(input int unsigned instr_w);
        return (instr_w > 8) ? $clog2(instr_w / 8) : 0;
    endfunction

endpackage

// File: rtl/imem_resp_if.sv
// Fetch-stage request/response bundle between the fetch stage (master) and
// the instruction-memory responder (slave). IMEM_RESP_PC_EN adds o_resp_pc.
interface imem_resp_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
);
    logic [ADDR_W-1:0]  i_pc;
    logic               i_instr_req;
    logic               i_stall;
    logic [INSTR_W-1:0] o_instr;
    logic               o_instr_valid;
    logic               o_fault;
    logic               o_stall;
`ifdef IMEM_RESP_PC_EN
    logic [ADDR_W-1:0]  o_resp_pc;
`endif

    modport master (
        output i_pc, i_instr_req, i_stall,
        input  o_instr, o_instr_valid, o_fault, o_stall
`ifdef IMEM_RESP_PC_EN
        , o_resp_pc
`endif
    );

    modport slave (
        input  i_pc, i_instr_req, i_stall,
        output o_instr, o_instr_valid, o_fault, o_stall
`ifdef IMEM_RESP_PC_EN
        , o_resp_pc
`endif
    );

endinterface

// File: rtl/imem_ld_asm.sv
// Byte-to-word assembler for the load port: collects little-endian bytes and
// strobes a complete (or zero-padded partial, on i_end) instruction word.
module imem_ld_asm
    import imem_resp_pkg::*;
#(
    parameter int unsigned INSTR_W = IMEM_INSTR_W
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               i_clear,
    input  logic               i_valid,
    input  logic [7:0]         i_byte,
    input  logic               i_end,
    output logic               o_word_valid,
    output logic [INSTR_W-1:0] o_word
);

    localparam int unsigned NB = INSTR_W / 8;
    localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

    logic [CW-1:0]      r_cnt;
    logic [INSTR_W-1:0] r_asm;
    logic [CW-1:0]      w_cnt_base;
    logic [INSTR_W-1:0] w_word;
    logic               w_word_valid;

    // i_clear acts in the same cycle so a byte arriving with it lands in lane 0
    always_comb begin
        w_cnt_base = i_clear ? '0 : r_cnt;
        w_word     = i_clear ? '0 : r_asm;
        if (i_valid) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (CW'(i) == w_cnt_base) w_word[i*8 +: 8] = i_byte;
            end
        end
        w_word_valid = (i_valid && (w_cnt_base == CW'(NB - 1))) ||
                       (i_end && (i_valid || (w_cnt_base != '0)));
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt <= '0;
            r_asm <= '0;
        end else if (w_word_valid) begin
            r_cnt <= '0;
            r_asm <= '0;
        end else if (i_valid) begin
            r_cnt <= w_cnt_base + CW'(1);
            r_asm <= w_word;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_asm <= '0;
        end
    end

    assign o_word_valid = w_word_valid;
    assign o_word       = w_word;

endmodule

// File: rtl/imem_resp.sv
// Instruction-memory responder: owns the instruction RAM, its byte-serial load
// port and the one-cycle fetch response. Optional IMEM_RESP_PC_EN adds o_resp_pc.
module imem_resp
    import imem_resp_pkg::*;
#(
    parameter int unsigned        DEPTH   = 256,
    parameter int unsigned        ADDR_W  = IMEM_ADDR_W,
    parameter int unsigned        INSTR_W = IMEM_INSTR_W,
    parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(IMEM_NOP)
) (
    input  logic        clk,
    input  logic        clr_n,
    imem_resp_if.slave  io_fetch,
    input  logic        i_ld_start,
    input  logic        i_ld_valid,
    input  logic [7:0]  i_ld_byte,
    input  logic        i_ld_end,
    output logic        o_ld_ovf
);

    localparam int unsigned NB = INSTR_W / 8;
    localparam int unsigned LB = lane_bits(INSTR_W);
    localparam int unsigned AW = $clog2(DEPTH);

    imem_state_e        r_state, w_state_nx;
    logic               w_stall;
    logic [AW:0]        r_ptr;
    logic               r_ovf;
    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;
    logic               r_fault;
`ifdef IMEM_RESP_PC_EN
    logic [ADDR_W-1:0]  r_resp_pc;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_state <= IMEM_HALT;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_stall    = 1'b1;
        unique case (r_state)
            IMEM_HALT: if (i_ld_start) w_state_nx = IMEM_LOAD;
            IMEM_LOAD: begin
                if (i_ld_start)    w_state_nx = IMEM_LOAD;
                else if (i_ld_end) w_state_nx = IMEM_RUN;
            end
            IMEM_RUN: begin
                w_stall = 1'b0;
                if (i_ld_start) w_state_nx = IMEM_LOAD;
            end
            default: w_state_nx = IMEM_HALT;
        endcase
    end

    // Load path
    logic               w_asm_valid, w_asm_end, w_word_valid, w_ptr_full, w_we;
    logic [INSTR_W-1:0] w_word;
    logic [AW:0]        w_ptr_base;

    assign w_asm_valid = ((r_state == IMEM_LOAD) || i_ld_start) && i_ld_valid;
    assign w_asm_end   = (r_state == IMEM_LOAD) && !i_ld_start && i_ld_end;

    imem_ld_asm #(.INSTR_W(INSTR_W)) u_ld_asm (
        .clk          (clk),
        .clr_n        (clr_n),
        .i_clear      (i_ld_start),
        .i_valid      (w_asm_valid),
        .i_byte       (i_ld_byte),
        .i_end        (w_asm_end),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    assign w_ptr_base = i_ld_start ? '0 : r_ptr;
    assign w_ptr_full = (w_ptr_base == (AW+1)'(DEPTH));
    assign w_we       = w_word_valid && !w_ptr_full;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_ptr <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (i_ld_start) begin
                r_ptr <= '0;
                r_ovf <= 1'b0;
            end
            if (w_word_valid) begin
                if (w_ptr_full) r_ovf <= 1'b1;
                else            r_ptr <= w_ptr_base + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_ptr_base[AW-1:0]] <= w_word;
    end

    // Fetch path; an i_ld_start in RUN drops the request sampled in that cycle
    logic [ADDR_W-1:0] w_word_idx;
    logic              w_bad, w_serve;

    assign w_word_idx = io_fetch.i_pc >> LB;
    assign w_bad      = (|(io_fetch.i_pc & ADDR_W'(NB - 1))) ||
                        (w_word_idx >= ADDR_W'(DEPTH));
    assign w_serve    = (r_state == IMEM_RUN) && !i_ld_start;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_instr   <= '0;
            r_valid   <= 1'b0;
            r_fault   <= 1'b0;
`ifdef IMEM_RESP_PC_EN
            r_resp_pc <= '0;
`endif
        end else if (!w_serve) begin
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else if (!io_fetch.i_stall) begin
            r_valid <= io_fetch.i_instr_req;
            r_fault <= io_fetch.i_instr_req && w_bad;
            if (io_fetch.i_instr_req) begin
                r_instr   <= w_bad ? NOP : r_mem[w_word_idx[AW-1:0]];
`ifdef IMEM_RESP_PC_EN
                r_resp_pc <= io_fetch.i_pc;
`endif
            end
        end
    end

    assign io_fetch.o_instr       = r_instr;
    assign io_fetch.o_instr_valid = r_valid;
    assign io_fetch.o_fault       = r_fault;
    assign io_fetch.o_stall       = w_stall;
`ifdef IMEM_RESP_PC_EN
    assign io_fetch.o_resp_pc     = r_resp_pc;
`endif
    assign o_ld_ovf               = r_ovf;

endmodule
